// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants and helpers for the BTB-equipped branch predictor.
package branch_predictor_btb_pkg;

  localparam int PRED_MODE_BIMODAL = 0;
  localparam int PRED_MODE_GSHARE  = 1;

  // Widest saturating counter the helper handles; callers zero-extend into it.
  localparam int SAT_CNT_MAX_W = 8;

  // Saturating step: count up on taken, down on not-taken, clamp at cnt_max and 0.
  function automatic logic [SAT_CNT_MAX_W-1:0] sat_cnt_next(
    input logic [SAT_CNT_MAX_W-1:0] cnt,
    input logic [SAT_CNT_MAX_W-1:0] cnt_max,
    input logic                     taken
  );
    if (taken) begin
      return (cnt == cnt_max) ? cnt : cnt + SAT_CNT_MAX_W'(1);
    end
    return (cnt == '0) ? cnt : cnt - SAT_CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter_table.sv
// Pattern history table: array of saturating counters, combinational read,
// one registered saturating update per cycle.
module sat_counter_table
  import branch_predictor_btb_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Weakly not-taken: one below the midpoint.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0]         tbl_q [DEPTH];
  logic [SAT_CNT_MAX_W-1:0] wr_next_ext;
  logic [CNT_W-1:0]         wr_cnt_d;
  logic                     unused_cnt_hi;

  assign rd_cnt_o = tbl_q[rd_idx_i];

  // Next value of the counter being trained.
  always_comb begin
    wr_next_ext = sat_cnt_next(SAT_CNT_MAX_W'(tbl_q[wr_idx_i]),
                               SAT_CNT_MAX_W'(CNT_MAX), wr_taken_i);
    wr_cnt_d    = wr_next_ext[CNT_W-1:0];
  end

  assign unused_cnt_hi = ^wr_next_ext;

  // Counter storage; reset loads every entry with the weakly not-taken value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CNT_INIT;
    end else if (wr_en_i) begin
      tbl_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Fetch-side branch predictor: direct-mapped BTB plus bimodal/gshare PHT.
// Lookup is combinational off fetch_pc; training from execute uses the GHR
// checkpoint carried with the instruction so it hits the entry used at fetch.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int GHR_W       = 8,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 2,
  parameter int MODE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             update_valid,
  input  logic [PC_W-1:0]  update_pc,
  input  logic             update_is_cond,
  input  logic             update_taken,
  input  logic [PC_W-1:0]  update_target,
  input  logic [GHR_W-1:0] update_ghr,
  output logic [GHR_W-1:0] ghr_out
);

  localparam int BI    = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - BI - 1;

  // Entry layout depends on instance widths, so it is declared here.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic             is_uncond;
  } btb_entry_t;

  btb_entry_t       btb_q [BTB_ENTRIES];
  btb_entry_t       fetch_entry;
  btb_entry_t       btb_wr_entry;
  logic             btb_wr_en;
  logic [BI-1:0]    fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;

  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [GHR_W-1:0] pht_rd_idx, pht_wr_idx;
  logic [CNT_W-1:0] pht_rd_cnt;
  logic             pht_wr_en;
  logic             unused_pc_lsb;

  function automatic logic [GHR_W-1:0] pht_index(input logic [PC_W-1:0]  pc,
                                                 input logic [GHR_W-1:0] ghr);
    if (MODE == PRED_MODE_GSHARE) return pc[GHR_W:1] ^ ghr;
    return pc[GHR_W:1];
  endfunction

  // Bit 0 never selects anything: with compressed instructions PCs are 2-byte aligned.
  assign fetch_idx     = fetch_pc[BI:1];
  assign fetch_tag     = fetch_pc[PC_W-1:BI+1];
  assign upd_idx       = update_pc[BI:1];
  assign upd_tag       = update_pc[PC_W-1:BI+1];
  assign unused_pc_lsb = fetch_pc[0] ^ update_pc[0];

  assign fetch_entry = btb_q[fetch_idx];
  assign pht_rd_idx  = pht_index(fetch_pc, ghr_q);

  // Lookup reads current state only, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_hit    = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    pred_taken  = pred_hit && (fetch_entry.is_uncond || pht_rd_cnt[CNT_W-1]);
    pred_target = pred_hit ? fetch_entry.target : '0;
  end

  assign pred_ghr = ghr_q;
  assign ghr_out  = ghr_q;

  // Training decode: PHT/GHR for conditionals, BTB allocate on any taken transfer.
  always_comb begin
    pht_wr_en    = update_valid && update_is_cond;
    pht_wr_idx   = pht_index(update_pc, update_ghr);
    // Rebuilt from the checkpoint, so a wrong-path history never survives.
    ghr_d        = pht_wr_en ? GHR_W'({update_ghr, update_taken}) : ghr_q;
    btb_wr_en    = update_valid && update_taken;
    btb_wr_entry = '{valid: 1'b1, tag: upd_tag, target: update_target,
                     is_uncond: !update_is_cond};
  end

  // Committed global history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ghr_q <= '0;
    else          ghr_q <= ghr_d;
  end

  // BTB storage; a taken transfer replaces whatever occupies its slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
    end else if (btb_wr_en) begin
      btb_q[upd_idx] <= btb_wr_entry;
    end
  end

  sat_counter_table #(
    .IDX_W (GHR_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_idx_i   (pht_rd_idx),
    .rd_cnt_o   (pht_rd_cnt),
    .wr_en_i    (pht_wr_en),
    .wr_idx_i   (pht_wr_idx),
    .wr_taken_i (update_taken)
  );

endmodule
